// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch front-end.
//   Drives code_address into a combinational program ROM and samples the
//   returned instruction in the same cycle. Fetched words enter a 2-entry
//   prefetch queue, each tagged with its fetch address. The queue head is
//   offered to decode through a valid/ready handshake. Execute can redirect
//   fetch, and halt suspends new fetches while the queue drains.
//
// Ports:
//   clk, rst       rising-edge clock, asynchronous active-high reset
//   code_address   ROM address (the fetch PC register)
//   instruction    ROM data for code_address, same cycle
//   instr_out      instruction at queue head (registered)
//   instr_pc       fetch address of the head instruction (registered)
//   instr_valid    queue non-empty
//   instr_ready    decode consumes the head when instr_valid & instr_ready
//   redirect       flush queue, restart fetch at redirect_pc
//   redirect_pc    new fetch address
//   halt           suspend fetching; queue still drains
module fetch_unit #(
  parameter int unsigned           ADDR_W   = 12,
  parameter int unsigned           INSTR_W  = 16,
  parameter logic [ADDR_W-1:0]     RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  code_address,
  input  logic [INSTR_W-1:0] instruction,
  output logic [INSTR_W-1:0] instr_out,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               redirect,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt
);

  // Queue occupancy encoded as a state.
  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_next;

  logic [ADDR_W-1:0]   r_fetch_pc;
  // Entry 0 (the head) is held directly in the output registers.
  logic [INSTR_W-1:0]  r_head_data;
  logic [ADDR_W-1:0]   r_head_pc;
  logic [INSTR_W-1:0]  r_q1_data;
  logic [ADDR_W-1:0]   r_q1_pc;

  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic                w_push_to_head;
  logic                w_push_to_q1;
  logic                w_shift;

  assign w_pop  = w_valid & instr_ready;
  assign w_push = ~redirect & ~halt & ((r_state != S_FULL) | w_pop);

  // The pushed word lands at index (count - pop): the head slot when that is
  // 0, otherwise the second slot. A pop from a full queue shifts entry 1 up.
  assign w_push_to_head = w_push & ((r_state == S_EMPTY) |
                                    ((r_state == S_ONE) & w_pop));
  assign w_push_to_q1   = w_push & (((r_state == S_ONE) & ~w_pop) |
                                    ((r_state == S_FULL) & w_pop));
  assign w_shift        = w_pop & (r_state == S_FULL);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (redirect) begin
      w_state_next = S_EMPTY;
    end else begin
      unique case ({w_push, w_pop})
        2'b10: begin
          case (r_state)
            S_EMPTY: w_state_next = S_ONE;
            S_ONE:   w_state_next = S_FULL;
            default: w_state_next = r_state;
          endcase
        end
        2'b01: begin
          case (r_state)
            S_FULL:  w_state_next = S_ONE;
            S_ONE:   w_state_next = S_EMPTY;
            default: w_state_next = r_state;
          endcase
        end
        default: w_state_next = r_state;
      endcase
    end
  end

  // Output logic
  always_comb begin
    w_valid = 1'b0;
    if (r_state != S_EMPTY) begin
      w_valid = 1'b1;
    end
  end

  // Fetch PC and queue storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc  <= RESET_PC;
      r_head_data <= '0;
      r_head_pc   <= '0;
      r_q1_data   <= '0;
      r_q1_pc     <= '0;
    end else if (redirect) begin
      // Entries are left in place; the empty state makes them invisible.
      r_fetch_pc <= redirect_pc;
    end else begin
      if (w_push) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
      if (w_shift) begin
        r_head_data <= r_q1_data;
        r_head_pc   <= r_q1_pc;
      end
      if (w_push_to_head) begin
        r_head_data <= instruction;
        r_head_pc   <= r_fetch_pc;
      end
      if (w_push_to_q1) begin
        r_q1_data <= instruction;
        r_q1_pc   <= r_fetch_pc;
      end
    end
  end

  assign code_address = r_fetch_pc;
  assign instr_out    = r_head_data;
  assign instr_pc     = r_head_pc;
  assign instr_valid  = w_valid;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a queue-based behavioural model.
module tb_fetch_unit;

  localparam int unsigned       AW  = 12;
  localparam int unsigned       IW  = 16;
  localparam logic [AW-1:0]     RPC = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] code_address;
  logic [IW-1:0] instruction;
  logic [IW-1:0] instr_out;
  logic [AW-1:0] instr_pc;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect;
  logic [AW-1:0] redirect_pc;
  logic          halt;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  // Model: fetch pc and a queue of {pc, data} entries.
  logic [AW-1:0]    m_pc;
  logic [AW+IW-1:0] m_q[$];

  always #5 clk = ~clk;

  function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
    logic [IW-1:0] p;
    p = {4'b0, a} * 16'h2F1B;
    return p ^ 16'h5A3C;
  endfunction

  assign instruction = rom(code_address);

  fetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .RESET_PC (RPC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .code_address (code_address),
    .instruction  (instruction),
    .instr_out    (instr_out),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .halt         (halt)
  );

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_step();
    int unsigned sz;
    bit pop, push;
    sz   = m_q.size();
    pop  = (sz != 0) && instr_ready;
    push = !redirect && !halt && ((sz < 2) || pop);
    if (redirect) begin
      m_q.delete();
      m_pc = redirect_pc;
    end else begin
      if (pop) void'(m_q.pop_front());
      if (push) begin
        m_q.push_back({m_pc, rom(m_pc)});
        m_pc = m_pc + 1'b1;
      end
    end
  endtask

  // Inputs are driven at the negedge; outputs are sampled at the next negedge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    instr_ready = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    halt        = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_pc = RPC;
  endtask

  task automatic test_reset();
    rst = 1'b1; instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
    @(negedge clk);
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", instr_valid);
    end
    checks++;
    if (code_address !== RPC) begin
      failures++; $display("FAIL reset_addr got=%h exp=%h", code_address, RPC);
    end
    checks++;
    if (instr_out !== '0 || instr_pc !== '0) begin
      failures++; $display("FAIL reset_head got=%h/%h exp=0/0", instr_out, instr_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_pc = RPC;
  endtask

  task automatic test_stream();
    logic [AW-1:0] e;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      e = AW'(i);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== e || instr_out !== rom(e)) begin
        failures++;
        $display("FAIL stream_head i=%0d got=%b/%h/%h exp=1/%h/%h",
                 i, instr_valid, instr_pc, instr_out, e, rom(e));
      end
      checks++;
      if (code_address !== e + 1'b1) begin
        failures++; $display("FAIL stream_addr i=%0d got=%h exp=%h", i, code_address, e + 1'b1);
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    tick(); tick();
    checks++;
    if (code_address !== 12'd2 || instr_valid !== 1'b1 || instr_pc !== 12'd0) begin
      failures++;
      $display("FAIL bp_fill got=%h/%b/%h exp=002/1/000", code_address, instr_valid, instr_pc);
    end
    tick();
    checks++;
    if (code_address !== 12'd2) begin
      failures++; $display("FAIL bp_freeze got=%h exp=002", code_address);
    end
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    checks++;
    if (code_address !== 12'd3 || instr_pc !== 12'd1 || instr_out !== rom(12'd1)) begin
      failures++;
      $display("FAIL bp_pop got=%h/%h exp=003/001", code_address, instr_pc);
    end
    tick();
    checks++;
    if (code_address !== 12'd3 || instr_valid !== 1'b1 || m_q.size() != 2) begin
      failures++; $display("FAIL bp_full got=%h/%b exp=003/1", code_address, instr_valid);
    end
  endtask

  // Runs from the full queue left by test_backpressure.
  task automatic test_redirect();
    redirect = 1'b1; redirect_pc = 12'h003; instr_ready = 1'b0;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || code_address !== 12'h003) begin
      failures++;
      $display("FAIL redir_flush got=%b/%h exp=0/003", instr_valid, code_address);
    end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== AW'(3 + k) || instr_out !== rom(AW'(3 + k))) begin
        failures++;
        $display("FAIL redir_seq k=%0d got=%b/%h exp=1/%h", k, instr_valid, instr_pc, AW'(3 + k));
      end
    end
  endtask

  task automatic test_wrap();
    logic [AW-1:0] e;
    redirect = 1'b1; redirect_pc = 12'hFFE; instr_ready = 1'b1;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || code_address !== 12'hFFE) begin
      failures++; $display("FAIL wrap_flush got=%b/%h exp=0/ffe", instr_valid, code_address);
    end
    e = 12'hFFE;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== e || instr_out !== rom(e)) begin
        failures++; $display("FAIL wrap_seq k=%0d got=%h exp=%h", k, instr_pc, e);
      end
      e = e + 1'b1;
    end
  endtask

  task automatic test_halt();
    logic [AW-1:0] held;
    instr_ready = 1'b1;
    held = m_pc;
    halt = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (code_address !== held) begin
        failures++; $display("FAIL halt_addr k=%0d got=%h exp=%h", k, code_address, held);
      end
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      failures++; $display("FAIL halt_drain got=%b exp=0", instr_valid);
    end
    halt = 1'b0;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== held || code_address !== held + 1'b1) begin
      failures++;
      $display("FAIL halt_resume got=%b/%h/%h exp=1/%h/%h",
               instr_valid, instr_pc, code_address, held, held + 1'b1);
    end
  endtask

  task automatic test_random();
    logic [AW+IW-1:0] e;
    for (int c = 0; c < 400; c++) begin
      instr_ready = ($urandom_range(0, 99) < 65);
      halt        = ($urandom_range(0, 99) < 15);
      redirect    = ($urandom_range(0, 99) < 10);
      redirect_pc = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(4093, 4095))
                                                : AW'($urandom_range(0, 4095));
      tick();
      checks++;
      if (instr_valid !== (m_q.size() != 0)) begin
        failures++;
        $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, instr_valid, m_q.size() != 0);
      end
      checks++;
      if (code_address !== m_pc) begin
        failures++; $display("FAIL rnd_addr c=%0d got=%h exp=%h", c, code_address, m_pc);
      end
      if (m_q.size() != 0) begin
        e = m_q[0];
        checks++;
        if ({instr_pc, instr_out} !== e) begin
          failures++;
          $display("FAIL rnd_head c=%0d got=%h/%h exp=%h/%h",
                   c, instr_pc, instr_out, e[AW+IW-1:IW], e[IW-1:0]);
        end
      end
    end
    instr_ready = 1'b0; halt = 1'b0; redirect = 1'b0;
  endtask

  task automatic test_async_reset();
    instr_ready = 1'b0; halt = 1'b0; redirect = 1'b1; redirect_pc = 12'h100;
    tick();
    redirect = 1'b0;
    tick(); tick(); tick();
    checks++;
    if (instr_valid !== 1'b1 || m_q.size() != 2 || code_address !== 12'h102) begin
      failures++; $display("FAIL arst_pre got=%b/%h exp=1/102", instr_valid, code_address);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || code_address !== RPC) begin
      failures++;
      $display("FAIL arst_now got=%b/%h exp=0/%h", instr_valid, code_address, RPC);
    end
    checks++;
    if (instr_out !== '0 || instr_pc !== '0) begin
      failures++; $display("FAIL arst_head got=%h/%h exp=0/0", instr_out, instr_pc);
    end
    @(negedge clk);
    rst = 1'b0;
    m_q.delete();
    m_pc = RPC;
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== RPC || instr_out !== rom(RPC)) begin
      failures++; $display("FAIL arst_restart got=%b/%h exp=1/%h", instr_valid, instr_pc, RPC);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_wrap();
    test_halt();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
